// File: rtl/snn_pkg.sv
// Shared types and constants for the spiking neural processor blocks.
// SPIKE_ENC_DITHER_EN selects a half-scale phase start for round-to-nearest spike counts.
package snn_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } enc_state_t;

    localparam int SNN_WEIGHT_W = 16;
    typedef logic [SNN_WEIGHT_W-1:0] snn_weight_t;

`ifdef SPIKE_ENC_DITHER_EN
    localparam bit DITHER_EN = 1'b1;
`else
    localparam bit DITHER_EN = 1'b0;
`endif

    // Starting phase of each window: half scale rounds the count, zero truncates it.
    function automatic logic [31:0] phase_init_f(input int dw);
        return DITHER_EN ? (32'd1 << (dw - 1)) : 32'd0;
    endfunction

endpackage

// File: rtl/spike_rate_encoder_if.sv
// Sample handshake plus spike/weight stream of the rate encoder.
// A sample transfers on a rising edge where sample_valid and sample_ready are both 1; the upstream holds it until then.
interface spike_rate_encoder_if #(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 9
);
    logic                  sample_valid;
    logic                  sample_ready;
    logic [DATA_WIDTH-1:0] sample_data;
    logic [DATA_WIDTH-1:0] sample_weight;
    logic                  spike_out;
    logic [DATA_WIDTH-1:0] weight_out;
    logic                  window_done;
    logic [CNT_WIDTH-1:0]  spike_count;

    modport master (
        output sample_valid, sample_data, sample_weight,
        input  sample_ready, spike_out, weight_out, window_done, spike_count
    );

    modport slave (
        input  sample_valid, sample_data, sample_weight,
        output sample_ready, spike_out, weight_out, window_done, spike_count
    );
endinterface

// File: rtl/spike_rate_encoder_phase_acc.sv
// Phase accumulator: the carry out of phase + data marks a spike slot.
module spike_phase_acc #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  step,
    input  logic [DATA_WIDTH-1:0] init,
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  carry
);
    logic [DATA_WIDTH-1:0] phase;
    logic [DATA_WIDTH:0]   sum;

    assign sum   = {1'b0, phase} + {1'b0, data};
    assign carry = sum[DATA_WIDTH];

    // Dropping the carry on update gives the modulo-2^DATA_WIDTH wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase <= '0;
        end else if (load) begin
            phase <= init;
        end else if (step) begin
            phase <= sum[DATA_WIDTH-1:0];
        end
    end
endmodule

// File: rtl/spike_rate_encoder.sv
// Rate encoder: one sample per window becomes a train of weighted single-cycle spikes.
// Build with SPIKE_ENC_DITHER_EN for round-to-nearest spike counts (see snn_pkg).
module spike_rate_encoder
    import snn_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int WINDOW_LEN = 256,
    parameter int CNT_WIDTH  = $clog2(WINDOW_LEN) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    spike_rate_encoder_if.slave   bus,
    output enc_state_t            state_dbg
);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;
    localparam logic [DATA_WIDTH-1:0] PHASE_INIT = DATA_WIDTH'(phase_init_f(DATA_WIDTH));
    localparam logic [CNT_WIDTH-1:0]  LAST_CYC   = CNT_WIDTH'(WINDOW_LEN - 1);

    logic [0:0]            state;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] weight_q;
    logic [CNT_WIDTH-1:0]  cyc_cnt;
    logic [CNT_WIDTH-1:0]  spike_cnt_q;
    logic                  spike_q;
    logic [DATA_WIDTH-1:0] weight_out_q;
    logic                  done_q;
    logic                  accept;
    logic                  in_run;
    logic                  carry;

    assign bus.sample_ready = (state == ST_IDLE);
    assign accept           = bus.sample_valid && (state == ST_IDLE);
    assign in_run           = (state == ST_RUN);

    assign bus.spike_out   = spike_q;
    assign bus.weight_out  = weight_out_q;
    assign bus.window_done = done_q;
    assign bus.spike_count = spike_cnt_q;
    assign state_dbg       = enc_state_t'(state);

    spike_phase_acc #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_phase_acc (
        .clk  (clk),
        .rst  (rst),
        .load (accept),
        .step (in_run),
        .init (PHASE_INIT),
        .data (data_q),
        .carry(carry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            data_q       <= '0;
            weight_q     <= '0;
            cyc_cnt      <= '0;
            spike_cnt_q  <= '0;
            spike_q      <= 1'b0;
            weight_out_q <= '0;
            done_q       <= 1'b0;
        end else begin
            // Spike and done outputs are pulses; they only survive an edge spent in RUN.
            spike_q      <= 1'b0;
            weight_out_q <= '0;
            done_q       <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        data_q      <= bus.sample_data;
                        weight_q    <= bus.sample_weight;
                        cyc_cnt     <= '0;
                        spike_cnt_q <= '0;
                        state       <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    spike_q      <= carry;
                    weight_out_q <= carry ? weight_q : '0;
                    if (carry) begin
                        spike_cnt_q <= spike_cnt_q + CNT_WIDTH'(1);
                    end
                    cyc_cnt <= cyc_cnt + CNT_WIDTH'(1);
                    if (cyc_cnt == LAST_CYC) begin
                        state  <= ST_IDLE;
                        done_q <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spike_rate_encoder.sv
// Directed bench for spike_rate_encoder at default parameters (16-bit data, 256-cycle window).
module tb_spike_rate_encoder;
    import snn_pkg::*;

    localparam int DW = 16;
    localparam int WL = 256;
    localparam int CW = 9;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    enc_state_t state_dbg;
    int         n_assert = 0;
    int         n_fail   = 0;
    logic [CW-1:0] exp_q[$];

    spike_rate_encoder_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) enc_if ();

    spike_rate_encoder #(
        .DATA_WIDTH(DW),
        .WINDOW_LEN(WL),
        .CNT_WIDTH (CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (enc_if.slave),
        .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ready"},  32'(enc_if.sample_ready), 32'd1);
        check({tag, "_spike"},  32'(enc_if.spike_out),    32'd0);
        check({tag, "_weight"}, 32'(enc_if.weight_out),   32'd0);
        check({tag, "_done"},   32'(enc_if.window_done),  32'd0);
        check({tag, "_count"},  32'(enc_if.spike_count),  32'd0);
        check({tag, "_state"},  32'(state_dbg),           32'(IDLE));
    endtask

    // mode: 0 no slot pattern, 1 even slots, 2 last slot only, 3 odd slots
    task automatic run_window(input string tag, input logic [DW-1:0] d, input logic [DW-1:0] w,
                              input int exp_cnt, input int mode);
        int waited  = 0;
        int seen    = 0;
        bit pat_bad = 1'b0;
        bit wt_bad  = 1'b0;
        bit dn_bad  = 1'b0;
        bit exp_sp;
        while (enc_if.sample_ready !== 1'b1 && waited < 1000) begin
            step();
            waited++;
        end
        check({tag, "_ready_wait"}, 32'(waited < 1000), 32'd1);
        enc_if.sample_valid  = 1'b1;
        enc_if.sample_data   = d;
        enc_if.sample_weight = w;
        step();
        enc_if.sample_valid  = 1'b0;
        enc_if.sample_data   = '0;
        enc_if.sample_weight = '0;
        check({tag, "_busy"}, 32'(enc_if.sample_ready), 32'd0);
        for (int i = 1; i <= WL; i++) begin
            step();
            case (mode)
                1:       exp_sp = (i % 2 == 0);
                2:       exp_sp = (i == WL);
                3:       exp_sp = (i % 2 == 1);
                default: exp_sp = enc_if.spike_out;
            endcase
            if (enc_if.spike_out !== exp_sp) pat_bad = 1'b1;
            if (enc_if.weight_out !== (enc_if.spike_out === 1'b1 ? w : '0)) wt_bad = 1'b1;
            if (enc_if.window_done !== (i == WL)) dn_bad = 1'b1;
            if (enc_if.spike_out === 1'b1) seen++;
            if (i == WL) check({tag, "_ready_at_done"}, 32'(enc_if.sample_ready), 32'd1);
        end
        check({tag, "_spikes_seen"}, 32'(seen), 32'(exp_cnt));
        check({tag, "_spike_count"}, 32'(enc_if.spike_count), 32'(exp_cnt));
        check({tag, "_weight_ok"},   32'(wt_bad), 32'd0);
        check({tag, "_done_slot"},   32'(dn_bad), 32'd0);
        if (mode != 0) check({tag, "_pattern"}, 32'(pat_bad), 32'd0);
        step();
        check({tag, "_done_pulse"},  32'(enc_if.window_done), 32'd0);
        check({tag, "_count_held"},  32'(enc_if.spike_count), 32'(exp_cnt));
    endtask

    initial begin : stimulus
        int acc_t[$];
        int done_cnt;
        int c;
        enc_if.sample_valid  = 1'b0;
        enc_if.sample_data   = '0;
        enc_if.sample_weight = '0;

        // reset then idle
        repeat (3) step();
        check_idle_outputs("reset");
        rst = 1'b0;
        repeat (2) step();
        check_idle_outputs("idle");

        // half-scale sample: alternate slots, 128 spikes
`ifdef SPIKE_ENC_DITHER_EN
        run_window("half", 16'h8000, 16'h0012, 128, 3);
`else
        run_window("half", 16'h8000, 16'h0012, 128, 1);
`endif
        run_window("zero", 16'h0000, 16'h00A5, 0, 0);
`ifdef SPIKE_ENC_DITHER_EN
        run_window("full", 16'hFFFF, 16'h7FFF, 256, 0);
        run_window("tiny", 16'h0080, 16'h0003, 1, 0);
        run_window("unit", 16'h0100, 16'h1234, 1, 0);
`else
        run_window("full", 16'hFFFF, 16'h7FFF, 255, 0);
        run_window("tiny", 16'h0080, 16'h0003, 0, 0);
        run_window("unit", 16'h0100, 16'h1234, 1, 2);
`endif

        // reset for 3 cycles in the middle of a window
        enc_if.sample_valid  = 1'b1;
        enc_if.sample_data   = 16'h4000;
        enc_if.sample_weight = 16'h0055;
        step();
        enc_if.sample_valid = 1'b0;
        repeat (50) step();
        check("midrst_running", 32'(state_dbg), 32'(RUN));
        rst = 1'b1;
        repeat (3) begin
            step();
            check_idle_outputs("midrst");
        end
        rst = 1'b0;
        repeat (4) step();
        check("midrst_no_done", 32'(enc_if.window_done), 32'd0);
        check_idle_outputs("after_rst");
`ifdef SPIKE_ENC_DITHER_EN
        run_window("post_rst", 16'h8000, 16'h0012, 128, 3);
`else
        run_window("post_rst", 16'h8000, 16'h0012, 128, 1);
`endif

        // sample_valid held high with data changing every cycle
        done_cnt = 0;
        c = 0;
        enc_if.sample_valid  = 1'b1;
        enc_if.sample_weight = 16'h0101;
        while (done_cnt < 3 && c < 2000) begin
            enc_if.sample_data = DW'(((c * 7) & 8'hFF) << 8);
            if (enc_if.sample_ready === 1'b1) begin
                acc_t.push_back(c);
                exp_q.push_back(CW'((c * 7) & 8'hFF));
            end
            step();
            c++;
            if (enc_if.window_done === 1'b1) begin
                done_cnt++;
                if (exp_q.size() > 0) check("stream_count", 32'(enc_if.spike_count), 32'(exp_q.pop_front()));
                else check("stream_extra_done", 32'd1, 32'd0);
            end
        end
        enc_if.sample_valid = 1'b0;
        check("stream_timeout", 32'(done_cnt), 32'd3);
        check("stream_accepts", 32'(acc_t.size()), 32'd3);
        if (acc_t.size() == 3) begin
            check("stream_period_1", 32'(acc_t[1] - acc_t[0]), 32'(WL + 1));
            check("stream_period_2", 32'(acc_t[2] - acc_t[1]), 32'(WL + 1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
